// File: rtl/ascii_wb_pkg.sv
// Shared definitions for the ASCII <-> Wishbone bridge pair: command/response
// characters, the initiator FSM state type and hex/ASCII conversion helpers.
package ascii_wb_pkg;

  localparam logic [7:0] CMD_READ  = 8'h72;  // 'r'
  localparam logic [7:0] CMD_WRITE = 8'h77;  // 'w'
  localparam logic [7:0] RESP_ERR  = 8'h78;  // 'x'

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_TX_CMD  = 4'd1,
    ST_TX_ADDR = 4'd2,
    ST_TX_DATA = 4'd3,
    ST_TX_MASK = 4'd4,
    ST_TX_TERM = 4'd5,
    ST_RX      = 4'd6,
    ST_RESP    = 4'd7,
    ST_DRAIN   = 4'd8
  } wb2ascii_state_t;

  // Nibble to lowercase hex character.
  function automatic logic [7:0] hex2ascii(input logic [3:0] nibble);
    logic [7:0] c;
    if (nibble < 4'd10) c = 8'h30 + {4'h0, nibble};
    else                c = 8'h57 + {4'h0, nibble};  // 'a' - 10
    return c;
  endfunction

  // Hex character (either case) to nibble; valid is low for non-hex input.
  function automatic logic [3:0] ascii2hex(input logic [7:0] ch, output logic valid);
    logic [3:0] n;
    n     = 4'h0;
    valid = 1'b0;
    if (ch >= 8'h30 && ch <= 8'h39) begin
      n     = ch[3:0];
      valid = 1'b1;
    end else if ((ch >= 8'h61 && ch <= 8'h66) || (ch >= 8'h41 && ch <= 8'h46)) begin
      n     = ch[3:0] + 4'd9;
      valid = 1'b1;
    end
    return n;
  endfunction

endpackage

// File: rtl/wishbone_if.sv
// Wishbone classic bus bundle with master and slave views.
interface wishbone_if #(
  parameter int ADR_BITS    = 16,
  parameter int PORT_SIZE   = 32,
  parameter int GRANULARITY = 8
);
  localparam int SEL_BITS = PORT_SIZE / GRANULARITY;

  logic                 cyc;
  logic                 stb;
  logic                 we;
  logic [ADR_BITS-1:0]  adr;
  logic [PORT_SIZE-1:0] dat_w;
  logic [SEL_BITS-1:0]  sel;
  logic [PORT_SIZE-1:0] dat_r;
  logic                 ack;
  logic                 err;
  logic                 stall;

  modport master (output cyc, stb, we, adr, dat_w, sel,
                  input  dat_r, ack, err, stall);
  modport slave  (input  cyc, stb, we, adr, dat_w, sel,
                  output dat_r, ack, err, stall);
endinterface

// File: rtl/ascii_line_rx.sv
// Reply line accumulator: shifts hex digits into a data word, counts them,
// flags a leading 'x' or any non-hex character, and strobes done on the
// terminator. The owner clears it before each new reply line.
module ascii_line_rx
  import ascii_wb_pkg::*;
#(
  parameter int         DATA_NIBBLES = 8,
  parameter logic [7:0] TERM_CHAR    = 8'h0A
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      i_clear,
  input  logic                      i_enable,
  input  logic [7:0]                i_data,
  input  logic                      i_strobe,
  output logic                      o_done,
  output logic [4*DATA_NIBBLES-1:0] o_data,
  output logic [7:0]                o_count,
  output logic                      o_xfirst,
  output logic                      o_bad
);
  localparam int DATA_W = 4 * DATA_NIBBLES;

  logic [DATA_W-1:0] r_shift;
  logic [7:0]        r_count;
  logic              r_first;
  logic              r_xfirst;
  logic              r_bad;

  logic       w_take;
  logic       w_is_term;
  logic       w_hex_ok;
  logic [3:0] w_nib;

  assign w_take    = i_enable & i_strobe;
  assign w_is_term = (i_data == TERM_CHAR);
  assign o_done    = w_take & w_is_term;

  // Decode the incoming character as a hex digit.
  always_comb begin
    w_hex_ok = 1'b0;
    w_nib    = ascii2hex(i_data, w_hex_ok);
  end

  // Accumulate one reply line; the digit count saturates so long lines never alias a valid length.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_shift  <= '0;
      r_count  <= '0;
      r_first  <= 1'b0;
      r_xfirst <= 1'b0;
      r_bad    <= 1'b0;
    end else if (i_clear) begin
      r_shift  <= '0;
      r_count  <= '0;
      r_first  <= 1'b1;
      r_xfirst <= 1'b0;
      r_bad    <= 1'b0;
    end else if (w_take && !w_is_term) begin
      r_first <= 1'b0;
      if (r_first && i_data == RESP_ERR) r_xfirst <= 1'b1;
      if (w_hex_ok) begin
        r_shift <= {r_shift[DATA_W-5:0], w_nib};
        if (r_count != 8'hFF) r_count <= r_count + 8'd1;
      end else begin
        r_bad <= 1'b1;
      end
    end
  end

  assign o_data   = r_shift;
  assign o_count  = r_count;
  assign o_xfirst = r_xfirst;
  assign o_bad    = r_bad;

endmodule

// File: rtl/wb2ascii.sv
// Wishbone slave to ASCII command-line bridge. Each bus request is sent as a
// hex text line ('w'+addr+data+mask or 'r'+addr, then terminator) and the
// reply line decides between ack and err. A transmitted line is always
// completed so the remote parser never sees a torn command.
module wb2ascii
  import ascii_wb_pkg::*;
#(
  parameter logic [7:0] TERM_CHAR      = 8'h0A,
  parameter int         DATA_NIBBLES   = 8,
  parameter int         ADDR_NIBBLES   = 4,
  parameter int         MASK_BITS      = 4,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  wishbone_if.slave  wb_s,
  output logic [7:0] ascii_tx_data_o,
  output logic       ascii_tx_strobe_o,
  input  logic       ascii_tx_ready_i,
  input  logic [7:0] ascii_rx_data_i,
  input  logic       ascii_rx_strobe_i,
  output logic       timeout_o
);
  localparam int DATA_W       = 4 * DATA_NIBBLES;
  localparam int ADDR_W       = 4 * ADDR_NIBBLES;
  localparam int MASK_NIBBLES = (MASK_BITS + 3) / 4;
  localparam int MASK_W       = 4 * MASK_NIBBLES;

  localparam logic [7:0]  ADDR_LAST = 8'(ADDR_NIBBLES - 1);
  localparam logic [7:0]  DATA_LAST = 8'(DATA_NIBBLES - 1);
  localparam logic [7:0]  MASK_LAST = 8'(MASK_NIBBLES - 1);
  localparam logic [7:0]  DATA_CNT  = 8'(DATA_NIBBLES);
  localparam logic [31:0] TMO_LIMIT = 32'(TIMEOUT_CYCLES);

  wb2ascii_state_t r_state;
  logic [7:0]        r_nib;
  logic              r_we;
  logic [ADDR_W-1:0] r_adr;
  logic [DATA_W-1:0] r_dat;
  logic [MASK_BITS-1:0] r_sel;
  logic              r_abandon;
  logic [31:0]       r_timer;
  logic              r_ack;
  logic              r_err;
  logic              r_timeout;
  logic [DATA_W-1:0] r_dat_r;

  logic [7:0]        w_tx_char;
  logic              w_tx_active;
  logic              w_adv;
  logic [3:0]        w_adr_nib;
  logic [3:0]        w_dat_nib;
  logic [3:0]        w_sel_nib;
  logic [MASK_W-1:0] w_sel_pad;
  logic [31:0]       w_timer_next;
  logic              w_abandon;
  logic              w_reply_ok;
  logic              w_rx_clear;
  logic              w_rx_done;
  logic [DATA_W-1:0] w_rx_data;
  logic [7:0]        w_rx_count;
  logic              w_rx_xfirst;
  logic              w_rx_bad;

  ascii_line_rx #(
    .DATA_NIBBLES (DATA_NIBBLES),
    .TERM_CHAR    (TERM_CHAR)
  ) u_line_rx (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .i_clear  (w_rx_clear),
    .i_enable (r_state == ST_RX),
    .i_data   (ascii_rx_data_i),
    .i_strobe (ascii_rx_strobe_i),
    .o_done   (w_rx_done),
    .o_data   (w_rx_data),
    .o_count  (w_rx_count),
    .o_xfirst (w_rx_xfirst),
    .o_bad    (w_rx_bad)
  );

  assign w_adr_nib = 4'(r_adr >> {r_nib, 2'b00});
  assign w_dat_nib = 4'(r_dat >> {r_nib, 2'b00});
  assign w_sel_nib = 4'(w_sel_pad >> {r_nib, 2'b00});

  // Widen the byte mask to a whole number of hex digits.
  always_comb begin
    w_sel_pad                = '0;
    w_sel_pad[MASK_BITS-1:0] = r_sel;
  end

  // Character currently offered to the TX sink, selected by state and nibble index.
  always_comb begin
    w_tx_active = 1'b1;
    w_tx_char   = 8'h00;
    case (r_state)
      ST_TX_CMD:  w_tx_char = r_we ? CMD_WRITE : CMD_READ;
      ST_TX_ADDR: w_tx_char = hex2ascii(w_adr_nib);
      ST_TX_DATA: w_tx_char = hex2ascii(w_dat_nib);
      ST_TX_MASK: w_tx_char = hex2ascii(w_sel_nib);
      ST_TX_TERM: w_tx_char = TERM_CHAR;
      default:    w_tx_active = 1'b0;
    endcase
  end

  assign w_adv             = w_tx_active & ascii_tx_ready_i;
  assign ascii_tx_strobe_o = w_adv;
  assign ascii_tx_data_o   = w_tx_char;
  assign w_rx_clear        = (r_state == ST_TX_TERM) && w_adv;
  assign w_timer_next      = r_timer + 32'd1;
  assign w_abandon         = r_abandon | ~wb_s.cyc;
  assign w_reply_ok        = r_we ? !w_rx_xfirst
                                  : (!w_rx_xfirst && !w_rx_bad && w_rx_count == DATA_CNT);

  // Transaction FSM: serialise the command, await the reply, then pulse ack/err.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state   <= ST_IDLE;
      r_nib     <= '0;
      r_we      <= 1'b0;
      r_adr     <= '0;
      r_dat     <= '0;
      r_sel     <= '0;
      r_abandon <= 1'b0;
      r_timer   <= '0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_timeout <= 1'b0;
      r_dat_r   <= '0;
    end else begin
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_timeout <= 1'b0;
      if (r_state != ST_IDLE && !wb_s.cyc) r_abandon <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (wb_s.cyc && wb_s.stb) begin
            r_we      <= wb_s.we;
            r_adr     <= wb_s.adr;
            r_dat     <= wb_s.dat_w;
            r_sel     <= wb_s.sel;
            r_abandon <= 1'b0;
            r_timer   <= '0;
            r_nib     <= '0;
            r_state   <= ST_TX_CMD;
          end
        end
        ST_TX_CMD: begin
          if (w_adv) begin
            r_nib   <= ADDR_LAST;
            r_state <= ST_TX_ADDR;
          end
        end
        ST_TX_ADDR: begin
          if (w_adv) begin
            if (r_nib != 8'd0) begin
              r_nib <= r_nib - 8'd1;
            end else if (r_we) begin
              r_nib   <= DATA_LAST;
              r_state <= ST_TX_DATA;
            end else begin
              r_state <= ST_TX_TERM;
            end
          end
        end
        ST_TX_DATA: begin
          if (w_adv) begin
            if (r_nib != 8'd0) begin
              r_nib <= r_nib - 8'd1;
            end else begin
              r_nib   <= MASK_LAST;
              r_state <= ST_TX_MASK;
            end
          end
        end
        ST_TX_MASK: begin
          if (w_adv) begin
            if (r_nib != 8'd0) r_nib <= r_nib - 8'd1;
            else               r_state <= ST_TX_TERM;
          end
        end
        ST_TX_TERM: begin
          // Timer holds the number of cycles elapsed since the terminator went out.
          if (w_adv) begin
            r_timer <= 32'd1;
            r_state <= ST_RX;
          end
        end
        ST_RX: begin
          if (w_rx_done) begin
            r_state <= ST_RESP;
            if (!w_abandon) begin
              if (w_reply_ok) begin
                r_ack <= 1'b1;
                if (!r_we) r_dat_r <= w_rx_data;
              end else begin
                r_err <= 1'b1;
              end
            end
          end else if (w_timer_next == TMO_LIMIT) begin
            r_timeout <= 1'b1;
            r_err     <= !w_abandon;
            r_state   <= ST_DRAIN;
          end else begin
            r_timer <= w_timer_next;
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        ST_DRAIN: begin
          if (ascii_rx_strobe_i && ascii_rx_data_i == TERM_CHAR) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign wb_s.ack   = r_ack;
  assign wb_s.err   = r_err;
  assign wb_s.dat_r = r_dat_r;
  assign wb_s.stall = (r_state != ST_IDLE);
  assign timeout_o  = r_timeout;

endmodule

// File: doc/wb2ascii.md
# wb2ascii

Wishbone-slave-to-ASCII bridge: the initiator end of the text command protocol that `ascii2wb` answers. It converts each Wishbone read or write into a hex command line on a byte-stream (UART) port. It then parses the responder's reply line and completes the bus cycle with `ack` or `err`. It lets one FPGA (or a soft CPU) drive a remote `ascii2wb`-equipped board, and it serves as the reusable host model in benches.

## Interface
- `TERM_CHAR`, default `'h0A`: line terminator, sent and expected.
- `DATA_NIBBLES`, default 8: hex digits per data word; data width = 4×`DATA_NIBBLES`.
- `ADDR_NIBBLES`, default 4: hex digits per address; address width = 4×`ADDR_NIBBLES`.
- `MASK_BITS`, default 4: byte-select bits; sent as ceil(`MASK_BITS`/4) hex digits.
- `TIMEOUT_CYCLES`, default 100000: maximum cycles from the terminator sent to the reply terminator received.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  **reset, synchronous, active-low.**
- `wb_s`  wishbone slave modport  (ADR_BITS=4×ADDR_NIBBLES, PORT_SIZE=4×DATA_NIBBLES, GRANULARITY=8)  bus side.
- `ascii_tx_data_o`  out  8  outgoing character.
- `ascii_tx_strobe_o`  out  1  one-cycle valid for `ascii_tx_data_o`.
- `ascii_tx_ready_i`  in  1  sink can accept a character this cycle.
- `ascii_rx_data_i`  in  8  incoming character.
- `ascii_rx_strobe_i`  in  1  one-cycle valid for `ascii_rx_data_i`.
- `timeout_o`  out  1  one-cycle pulse when a transaction times out.

## Operation
- Wishbone classic cycles: a request is `cyc & stb` sampled in IDLE. The block latches `we`, `adr`, `dat_w` and `sel` at that point. Exactly one `ack` or `err` pulse per request.
- Write line: `w` + address + data + mask + `TERM_CHAR`. Read line: `r` + address + `TERM_CHAR`. Hex digits are MSB-first, lowercase.
  - Example: write 0x0004 ← 0xFFFFFFFF, sel 0xF gives `w0004fffffffff\n`.
- Reply parsing:
  - Hex digits are accepted in either case and shifted into the data register.
  - A line whose first character is `x` is an error.
  - Any other non-hex character is an error.
  - A read reply with a digit count other than `DATA_NIBBLES` is an error.
  - A write reply is any line not starting with `x`; its content is ignored.
  - The reply is evaluated on `TERM_CHAR`: OK → `ack`, with `dat_r` = parsed data for a read. Anything else → `err`.
- Timeout: if the counter reaches `TIMEOUT_CYCLES` in RX, the block asserts `err` plus `timeout_o` and returns to IDLE. Characters arriving after that, up to the next `TERM_CHAR`, are discarded (DRAIN).
- `rx` characters arriving in IDLE or TX are ignored.
- States:
  - IDLE → TX_CMD on request.
  - TX_CMD → TX_ADDR → TX_DATA → TX_MASK → TX_TERM for a write. A read skips TX_DATA and TX_MASK.
  - TX_TERM → RX.
  - RX → RESP on `TERM_CHAR`, or RX → DRAIN on timeout.
  - RESP → IDLE.
  - DRAIN → IDLE on `TERM_CHAR`.
- Nibble index counters count down from N-1. A counter wraps only on a state change.

## Timing
- Reset values:
  - All outputs are 0: `ack`, `err`, `dat_r`, `ascii_tx_data_o`, `ascii_tx_strobe_o`, `timeout_o`.
  - `stall` follows `!IDLE`.
  - State is IDLE; counters are 0.
- TX pacing:
  - `strobe` is asserted only in a cycle where `ascii_tx_ready_i` is 1, and the character advances in that same cycle.
  - With `ready` held at 1, characters go out back-to-back, one per cycle.
  - The first character is issued the cycle after the request is accepted.
  - Write line length = 2 + ADDR_NIBBLES + DATA_NIBBLES + ceil(MASK_BITS/4) cycles; for the defaults that is 15.
- Response latency: `ack`/`err` is driven 1 cycle after the cycle in which `TERM_CHAR` is received with its rx strobe.
- Mid-transaction `cyc` drop: the line finishes and the reply is consumed, but no `ack` is generated. Abandoning a partially sent line would corrupt the responder's parse, so the line is never cut short.
- Reset low mid-line: immediate return to IDLE, and `strobe` goes to 0 in the next cycle. A truncated line is the responder's concern.
- The timeout counter runs only in RX and restarts on every request.

## Structure
- Package `ascii_wb_pkg`, shared with `ascii2wb`:
  - functions `hex2ascii(nibble)` and `ascii2hex(char, output valid)`;
  - constants `CMD_READ='r'`, `CMD_WRITE='w'`, `RESP_ERR='x'`;
  - the state enum `wb2ascii_state_t`.
- One sub-module, `ascii_line_rx`: an RX accumulator with a shift register, a digit counter and an error flag, plus a `done` strobe on `TERM_CHAR`.
- The TX serializer stays inline in `wb2ascii`.

## Test plan
- **Write, ready held at 1.** Write 0x0004 ← 0xFFFFFFFF, sel 0xF → exact stream `w0004fffffffff\n` with 15 consecutive strobes. Then feed reply `k\n` → `ack` one cycle after the `\n`.
- **Read.** Read 0x000C with reply `0000000A\n` → sent `r000c\n`; `ack` with `dat_r`=0x0000000A. Uppercase hex in the reply is accepted.
- **Backpressure.** `ready` toggles 1,0,0,1… → no character dropped or duplicated, and `strobe` never asserted while `ready` is 0.
- **Errors.**
  - Reply `x\n` → `err` with no `ack`.
  - Read reply `123\n` (short) → `err`.
  - Reply `00g00000\n` → `err`.
- **Timeout.** With `TIMEOUT_CYCLES`=50 and no reply → `err` and `timeout_o` at cycle 50. Then a late `5\n` is drained, and the next request completes normally.
- **Reset.** Reset asserted after 5 characters of a write line → `strobe` is 0 the next cycle, state is IDLE, and a fresh read then works.
